// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the write-back arbiter slice.
package wb_arb_pkg;

  localparam int ZERO_REG_DEFAULT = 31;

  typedef enum logic {
    GNT_SRC0 = 1'b0,
    GNT_SRC1 = 1'b1
  } grant_t;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/mux128_64.sv
// mux128_64: 64-bit 2:1 result mux cell; sel=1 passes inOne, sel=0 passes inZero.
module mux128_64 (
  input  logic [63:0] inOne,
  input  logic [63:0] inZero,
  input  logic        sel,
  output logic [63:0] muxOut
);

  assign muxOut = sel ? inOne : inZero;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter between the EX result path (src0) and the
// slow path (src1) for the single register-file write port. The winner is
// registered into one output stage with a valid/ready handshake.
// Optional feature: define WB_ARB_CONFLICT_CNT_EN to add the saturating
// conflict_cnt port counting cycles where both sources compete for a free stage.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src0_valid,
  input  logic [63:0]      src0_data,
  input  logic [REG_W-1:0] src0_rd,
  output logic             src0_ready,
  input  logic             src1_valid,
  input  logic [63:0]      src1_data,
  input  logic [REG_W-1:0] src1_rd,
  output logic             src1_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_we,
  output logic [REG_W-1:0] wb_rd,
  output logic [63:0]      wb_data,
  output logic             wb_sel
`ifdef WB_ARB_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  grant_t             last_grant;
  grant_t             grant;
  logic               any_valid;
  logic               can_load;
  logic [63:0]        mux_data;
  logic [REG_W-1:0]   sel_rd;

  assign any_valid = src0_valid || src1_valid;
  assign can_load  = !wb_valid || wb_ready;

  // Pick the winner: a lone requester always wins, a conflict goes to whoever did not win last
  always_comb begin
    grant = last_grant;
    if (src0_valid && src1_valid) begin
      grant = (last_grant == GNT_SRC0) ? GNT_SRC1 : GNT_SRC0;
    end else if (src1_valid) begin
      grant = GNT_SRC1;
    end else if (src0_valid) begin
      grant = GNT_SRC0;
    end
  end

  assign wb_sel     = (grant == GNT_SRC1);
  assign src0_ready = can_load && any_valid && !wb_sel;
  assign src1_ready = can_load && any_valid && wb_sel;
  assign sel_rd     = wb_sel ? src1_rd : src0_rd;
  assign wb_we      = wb_valid && (wb_rd != ZERO_IDX);

  mux128_64 u_mux (
    .inOne  (src1_data),
    .inZero (src0_data),
    .sel    (wb_sel),
    .muxOut (mux_data)
  );

  // Output stage: load the winner when the stage is free, hold everything under backpressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      last_grant <= GNT_SRC1;
    end else if (can_load) begin
      wb_valid <= any_valid;
      if (any_valid) begin
        wb_rd      <= sel_rd;
        wb_data    <= mux_data;
        last_grant <= grant;
      end
    end
  end

`ifdef WB_ARB_CONFLICT_CNT_EN
  // Count cycles where both sources compete for a free stage, sticking at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (src0_valid && src1_valid && can_load && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A source must keep offering its result until it has been accepted
  property p_src0_hold;
    @(posedge clk) disable iff (!reset) (src0_valid && !src0_ready) |=> src0_valid;
  endproperty
  property p_src1_hold;
    @(posedge clk) disable iff (!reset) (src1_valid && !src1_ready) |=> src1_valid;
  endproperty
  a_src0_hold : assert property (p_src0_hold);
  a_src1_hold : assert property (p_src1_hold);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random stimulus for wb_arbiter, compared against
// a transaction-level reference model of the round-robin write port.
// Honours WB_ARB_CONFLICT_CNT_EN when it is defined for the build.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        src0_valid, src1_valid;
  logic [63:0] src0_data, src1_data;
  logic [4:0]  src0_rd, src1_rd;
  logic        src0_ready, src1_ready;
  logic        wb_valid, wb_ready, wb_we, wb_sel;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
`ifdef WB_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int nchecks = 0;
  int nerrs   = 0;

  // Reference model: what the write port should be holding, who won last, conflicts seen
  logic        m_valid;
  reg_idx_t    m_rd;
  logic [63:0] m_data;
  int          m_last;
  int          m_cnt;

  logic        acc0, acc1;
  logic        p0, p1;
  logic [63:0] d0, d1;
  reg_idx_t    r0, r1;
  logic        wbr;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .src0_valid   (src0_valid),
    .src0_data    (src0_data),
    .src0_rd      (src0_rd),
    .src0_ready   (src0_ready),
    .src1_valid   (src1_valid),
    .src1_data    (src1_data),
    .src1_rd      (src1_rd),
    .src1_ready   (src1_ready),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_sel       (wb_sel)
`ifdef WB_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrs++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_rd    = '0;
    m_data  = '0;
    m_last  = 1;
    m_cnt   = 0;
  endtask

  // Compare the registered write port against the model
  task automatic checkOutput();
    check("wb_valid", 64'(wb_valid), 64'(m_valid));
    check("wb_we", 64'(wb_we), 64'(m_valid && (m_rd != 5'd31)));
    check("wb_rd", 64'(wb_rd), 64'(m_rd));
    check("wb_data", wb_data, m_data);
`ifdef WB_ARB_CONFLICT_CNT_EN
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
  endtask

  // Drive one cycle from the low clock phase, check the grant, advance the model, check after the edge
  task automatic applyStimulus(input logic v0, input logic [63:0] dd0, input reg_idx_t rr0,
                               input logic v1, input logic [63:0] dd1, input reg_idx_t rr1,
                               input logic rdy, output logic a0, output logic a1);
    logic canl, anyv;
    int   g;
    src0_valid = v0;  src0_data = dd0;  src0_rd = rr0;
    src1_valid = v1;  src1_data = dd1;  src1_rd = rr1;
    wb_ready   = rdy;
    #1;
    canl = !m_valid || rdy;
    anyv = v0 || v1;
    if (v0 && v1)  g = 1 - m_last;
    else if (v1)   g = 1;
    else if (v0)   g = 0;
    else           g = m_last;
    a0 = canl && anyv && (g == 0);
    a1 = canl && anyv && (g == 1);
    check("src0_ready", 64'(src0_ready), 64'(a0));
    check("src1_ready", 64'(src1_ready), 64'(a1));
    check("wb_sel", 64'(wb_sel), 64'(g));
    if (canl) begin
      if (v0 && v1 && m_cnt < 65535) m_cnt++;
      if (anyv) begin
        m_valid = 1'b1;
        m_rd    = (g == 1) ? rr1 : rr0;
        m_data  = (g == 1) ? dd1 : dd0;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    src0_valid = 1'b0; src0_data = '0; src0_rd = '0;
    src1_valid = 1'b0; src1_data = '0; src1_rd = '0;
    wb_ready   = 1'b0;
    model_reset();

    // Reset held for three cycles, then idle
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, '0, 5'd0, 0, '0, 5'd0, 1, acc0, acc1);

    // Single src0 transfer, then the stage empties
    applyStimulus(1, 64'hDEAD_BEEF_0000_0001, 5'd5, 0, '0, 5'd0, 1, acc0, acc1);
    applyStimulus(0, '0, 5'd0, 0, '0, 5'd0, 1, acc0, acc1);

    // Lone src1 so src0 wins the next conflict, then four conflict cycles
    applyStimulus(0, '0, 5'd0, 1, 64'h55, 5'd2, 1, acc0, acc1);
    repeat (4) applyStimulus(1, 64'h0, 5'd3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1, acc0, acc1);
    applyStimulus(1, 64'h0, 5'd3, 0, '0, 5'd0, 1, acc0, acc1);
    applyStimulus(0, '0, 5'd0, 0, '0, 5'd0, 1, acc0, acc1);

    // Backpressure after loading src1, src0 waiting, then release
    applyStimulus(0, '0, 5'd0, 1, 64'hABCD_0000_9999_0009, 5'd9, 0, acc0, acc1);
    repeat (3) applyStimulus(1, 64'h4444, 5'd4, 0, '0, 5'd0, 0, acc0, acc1);
    applyStimulus(1, 64'h4444, 5'd4, 0, '0, 5'd0, 1, acc0, acc1);
    applyStimulus(0, '0, 5'd0, 0, '0, 5'd0, 1, acc0, acc1);

    // Write to the zero register occupies a slot without enabling the write
    applyStimulus(0, '0, 5'd0, 1, 64'h1234, 5'd31, 1, acc0, acc1);
    applyStimulus(0, '0, 5'd0, 0, '0, 5'd0, 1, acc0, acc1);

    // Asynchronous reset while a write is being held
    applyStimulus(1, 64'h6666, 5'd6, 0, '0, 5'd0, 1, acc0, acc1);
    applyStimulus(0, '0, 5'd0, 0, '0, 5'd0, 0, acc0, acc1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checkOutput();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic: sources hold their offer until accepted
    p0 = 1'b0; p1 = 1'b0;
    d0 = '0; d1 = '0; r0 = '0; r1 = '0;
    for (int i = 0; i < 300; i++) begin
      if (!p0) begin
        p0 = ($urandom_range(0, 1) == 1);
        d0 = {$urandom, $urandom};
        r0 = 5'($urandom_range(0, 31));
      end
      if (!p1) begin
        p1 = ($urandom_range(0, 2) != 0);
        d1 = {$urandom, $urandom};
        r1 = 5'($urandom_range(0, 31));
      end
      wbr = ($urandom_range(0, 3) != 0);
      applyStimulus(p0, d0, r0, p1, d1, r1, wbr, acc0, acc1);
      if (acc0) p0 = 1'b0;
      if (acc1) p1 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
